// File: rtl/imem_loader_pkg.sv
// Shared constants and FSM state type for the instruction-memory byte loader.
package imem_loader_pkg;

    localparam int unsigned IMEM_WORD_W = 32;
    localparam int unsigned IMEM_ADDR_W = 7;
    localparam int unsigned IMEM_DEPTH  = 2 ** IMEM_ADDR_W;
    localparam int unsigned IMEM_BPW    = IMEM_WORD_W / 8;
    localparam int unsigned COUNT_W     = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Counter width for n items, never below one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int unsigned N      = IMEM_WORD_W,
    parameter int unsigned ADDR_W = IMEM_ADDR_W
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [N-1:0]      wdata;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, we, waddr, wdata
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, we, waddr, wdata
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler; flags the byte that completes a word.
module byte_packer
    import imem_loader_pkg::*;
#(
    parameter int unsigned N = IMEM_WORD_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         in_valid,
    input  logic [7:0]   in_byte,
    output logic         word_ready_c,
    output logic [N-1:0] word_c
);

    localparam int unsigned BPW    = N / 8;
    localparam int unsigned BCNT_W = cnt_width(BPW);

    logic [N-1:0]      sr;
    logic [BCNT_W-1:0] cnt;

    // Current partial word with the incoming byte dropped into its lane.
    always_comb begin
        word_c = sr;
        for (int k = 0; k < int'(BPW); k++) begin
            if (cnt == BCNT_W'(k)) begin
                word_c[8*k +: 8] = in_byte;
            end
        end
        word_ready_c = in_valid && (cnt == BCNT_W'(BPW - 1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (clear) begin
            sr  <= '0;
            cnt <= '0;
        end else if (in_valid) begin
            sr  <= word_c;
            cnt <= (cnt == BCNT_W'(BPW - 1)) ? '0 : cnt + BCNT_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads the instruction memory from a byte stream while holding the CPU in reset.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned N      = IMEM_WORD_W,
    parameter int unsigned ADDR_W = IMEM_ADDR_W,
    parameter int unsigned DEPTH  = IMEM_DEPTH
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [COUNT_W-1:0] count,
    imem_loader_if.master      bus,
    output logic               hold_cpu,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    state_t state, next_state;

    logic [CNT_W-1:0]  count_q, count_d, count_sat_c;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              byte_ready_q, ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [N-1:0]      wdata_q, wdata_d;
    logic              hold_q, hold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept_c;
    logic              pk_valid_c;
    logic              clr_c;
    logic              last_word_c;
    logic              word_ready_c;
    logic [N-1:0]      word_c;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] cks_q, cks_d;
    localparam state_t END_STATE = S_CHECK;
`else
    localparam state_t END_STATE = S_DONE;
`endif

    assign accept_c    = bus.byte_valid && byte_ready_q;
    assign pk_valid_c  = accept_c && (state == S_LOAD);
    assign last_word_c = ({1'b0, addr_q} == (count_q - CNT_W'(1)));

    // Requests beyond the memory depth are clipped so the address never wraps.
    always_comb begin
        if (32'(count) > DEPTH) begin
            count_sat_c = CNT_W'(DEPTH);
        end else begin
            count_sat_c = CNT_W'(count);
        end
    end

    byte_packer #(.N(N)) u_packer (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clr_c),
        .in_valid     (pk_valid_c),
        .in_byte      (bus.byte_data),
        .word_ready_c (word_ready_c),
        .word_c       (word_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus the values every output register takes at the coming edge.
    always_comb begin
        next_state = state;
        clr_c      = 1'b0;
        count_d    = count_q;
        addr_d     = addr_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        cks_d      = cks_q;
`endif

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    clr_c   = 1'b1;
                    count_d = count_sat_c;
                    addr_d  = '0;
                    err_d   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    cks_d   = '0;
`endif
                    next_state = (count_sat_c == '0) ? END_STATE : S_LOAD;
                end
            end
            S_LOAD: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (pk_valid_c) begin
                    cks_d = cks_q ^ bus.byte_data;
                end
`endif
                if (word_ready_c) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = word_c;
                    if (last_word_c) begin
                        next_state = END_STATE;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept_c) begin
                    err_d      = (bus.byte_data != cks_q);
                    next_state = S_DONE;
                end
            end
`endif
            default: begin
                next_state = S_IDLE;
            end
        endcase

        busy_d  = (next_state == S_LOAD) || (next_state == S_CHECK);
        ready_d = busy_d;
        done_d  = (next_state == S_DONE);
        hold_d  = busy_d || ((next_state == S_DONE) && err_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q      <= '0;
            addr_q       <= '0;
            byte_ready_q <= 1'b0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            hold_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            count_q      <= count_d;
            addr_q       <= addr_d;
            byte_ready_q <= ready_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            hold_q       <= hold_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cks_q <= '0;
        end else begin
            cks_q <= cks_d;
        end
    end
`endif

    assign bus.byte_ready = byte_ready_q;
    assign bus.we         = we_q;
    assign bus.waddr      = waddr_q;
    assign bus.wdata      = wdata_q;
    assign hold_cpu       = hold_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule
